ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
Fetch sequencer for the byte-addressable instruction memory in the IFU.
- Owns the program counter.
- Arbitrates the memory between a byte-wide program loader (boot/test path) and instruction fetch.
- Registers fetched words toward decode, and supports stall, branch redirect, end-of-program halt and address-error trapping.
- Sits between the instruction memory (async read, new synchronous byte write port) and the decode stage.

Parameters:
MEM_BYTES, 32, instruction memory size in bytes; multiple of 4, power of two.
ADDR_W, 5, log2(MEM_BYTES); width of loader byte address.
RESET_PC, 0, PC value loaded on reset and on each start; word aligned.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle pulse: begin fetching at RESET_PC
load_valid  input  1  loader byte valid
load_ready  output  1  controller accepts loader bytes
load_addr  input  ADDR_W  loader byte address
load_data  input  8  loader byte
mem_we  output  1  byte write enable to instruction memory
mem_waddr  output  ADDR_W  byte write address
mem_wdata  output  8  byte write data
pc  output  32  read address driven to instruction memory
instr_in  input  32  little-endian word read combinationally at pc
stall  input  1  decode back-pressure; hold fetch
redirect  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
fetch_valid  output  1  instr_out/instr_pc hold a valid instruction
instr_out  output  32  registered instruction to decode
instr_pc  output  32  address of instr_out
busy  output  1  state is FETCH
done  output  1  state is HALT
addr_err  output  1  sticky; state is ERROR

Behaviour:
- Reset (reset=0, asynchronous, any state, mid-load or mid-fetch):
  - State IDLE; pc=RESET_PC.
  - instr_out=0, instr_pc=0, fetch_valid=0, addr_err=0.
  - Outputs are valid immediately, without waiting for a clock edge.
- States: IDLE, FETCH, HALT, ERROR.
- load_ready=1 only in IDLE and HALT.
- Loader write:
  - Handshake completes when load_valid&&load_ready.
  - mem_we=load_valid&&load_ready, combinational, same cycle.
  - mem_waddr=load_addr and mem_wdata=load_data pass through.
  - One byte per handshake; no buffering.
- IDLE/HALT:
  - start with no load handshake: next state FETCH, pc<=RESET_PC, fetch_valid<=0.
  - start in the same cycle as a load handshake: the byte is written and start is ignored; the loader must re-pulse start.
- FETCH, each rising edge, priority order:
  1. redirect=1 with redirect_pc[1:0]!=0 or redirect_pc>MEM_BYTES-4: next state ERROR, addr_err<=1, fetch_valid<=0.
  2. redirect=1 with a legal target: pc<=redirect_pc, fetch_valid<=0. The word at the old pc is squashed. Redirect overrides stall.
  3. stall=1: pc, instr_out, instr_pc and fetch_valid all hold.
  4. Otherwise: instr_out<=instr_in, instr_pc<=pc, fetch_valid<=1.
     - If pc==MEM_BYTES-4: next state HALT and pc holds; this last word is still delivered.
     - Else pc<=pc+4.
- Latency: the word at pc appears on instr_out one cycle after it is presented. With no stalls there is one instruction per cycle, and the first fetch_valid comes 2 cycles after start.
- HALT:
  - fetch_valid<=0 on the first cycle where stall=0 (the last word is held while stalled).
  - done=1.
  - start re-enters FETCH from RESET_PC.
- ERROR:
  - fetch_valid=0, addr_err=1, load_ready=0.
  - Exit only via reset.
- Arithmetic:
  - pc is 32 bits; pc+4 is unsigned 32-bit with no wrap by construction, since HALT precedes overflow.
  - Only pc[ADDR_W-1:0] is meaningful to the memory.
- Outputs outside FETCH: pc holds its last value; instr_out/instr_pc hold their last value; fetch_valid is 0 except as noted for HALT.

Test Plan:
- Load bytes 0..31 via the loader with words 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33, 0x019c1eb3, 0x01bd5f33, 0x00d67fb3, 0x00f768b3, then pulse start -> mem_we once per byte.
  - Starting 2 cycles after start: 8 consecutive fetch_valid cycles with instr_pc 0,4,...,28 and the listed words.
  - Then done=1 and fetch_valid=0.
- Hold stall for 3 cycles while instr_pc=8 -> instr_out stays 0x035a02b3 and pc stays 12; on release the next output is instr_pc=12, 0x017b4e33.
- Redirect to 0x4 while pc=20 -> the next cycle has fetch_valid=0; the following cycle has instr_pc=4, 0x413903b3, and the sequence continues from there.
- Redirect to 0x6 (misaligned), and separately to 0x20 (out of range) -> ERROR: addr_err=1, fetch_valid=0, start and load ignored until reset.
- start together with load_valid in IDLE -> the byte is written and the state stays IDLE; a later lone start enters FETCH.
- Assert reset=0 mid-fetch, between clock edges -> fetch_valid, addr_err and instr_out go to 0 and pc=RESET_PC immediately; after reset=1 and start, fetch restarts at 0.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates the instruction memory between the byte loader and fetch.
// Latency: the word at pc reaches instr_out one cycle later; loader bytes are written in the cycle they are offered.
// Backpressure: stall holds pc and the output word; load_ready is high only while IDLE or HALT.
module ifu_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [31:0]       pc,
  input  logic [31:0]       instr_in,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_valid,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Address of the last whole word in memory; fetching it ends the program.
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fv_q, fv_d;

  logic        load_hs;
  logic        redirect_bad;

  // Loader byte path is a straight pass-through, gated only by the handshake.
  always_comb begin
    load_ready = (state_q == IDLE) || (state_q == HALT);
    load_hs    = load_valid && load_ready;
    mem_we     = load_hs;
    mem_waddr  = load_addr;
    mem_wdata  = load_data;
  end

  // A redirect target must be word aligned and point at a whole word inside memory.
  always_comb begin
    redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);
  end

  // Next-state and datapath update; redirect beats stall, a colliding load beats start.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE: begin
        fv_d = 1'b0;
        if (start && !load_hs) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      FETCH: begin
        if (redirect && redirect_bad) begin
          state_d = ERROR;
          fv_d    = 1'b0;
        end else if (redirect) begin
          // The word currently at pc is squashed.
          pc_d = redirect_pc;
          fv_d = 1'b0;
        end else if (!stall) begin
          instr_d = instr_in;
          ipc_d   = pc_q;
          fv_d    = 1'b1;
          if (pc_q == LAST_PC) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HALT: begin
        if (start && !load_hs) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          fv_d    = 1'b0;
        end else if (!stall) begin
          // The final word stays visible until decode stops stalling.
          fv_d = 1'b0;
        end
      end
      default: begin
        fv_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset takes effect immediately, not at the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fv_q    <= fv_d;
    end
  end

  // Status and decode-facing outputs straight from the registers.
  always_comb begin
    pc          = pc_q;
    instr_out   = instr_q;
    instr_pc    = ipc_q;
    fetch_valid = fv_q;
    busy        = (state_q == FETCH);
    done        = (state_q == HALT);
    addr_err    = (state_q == ERROR);
  end

endmodule
